uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver; the stage directly downstream of the transmitter. It consumes the serial line that the transmitter drives on o_Tx_Serial.
- Frame format: 8N1, LSB first. With UART_RX_PARITY_EN defined, the frame is 8E1.
- Samples each bit at its mid-point and presents the received byte with a one-cycle valid strobe.
- Feeds the board-level seven-segment display path and user logic.

Parameters:
- CLKS_PER_BIT, 5208: i_Clock cycles per bit (50 MHz / 9600 baud). Legal range is 4 or more.
- CNT_W, $clog2(CLKS_PER_BIT): width of the bit-period counter. Derived; do not override.

Ports:
- i_Clock  input  1  system clock; all logic on the rising edge.
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_Rx_Serial  input  1  asynchronous serial line; idles high.
- o_Rx_DV  output  1  one-cycle pulse; o_Rx_Byte is valid and new.
- o_Rx_Byte  output  8  last correctly received byte; held between pulses.
- o_Rx_Active  output  1  high while a frame is in progress.
- o_Frame_Err  output  1  one-cycle pulse; stop bit (or parity) check failed.

Behaviour:
- Clocking and reset: one clock, i_Clock. Reset i_Rst_n is asynchronous and active-low.
- Reset values:
  - o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Active=0, o_Frame_Err=0.
  - Both synchronizer flops reset to 1. State=IDLE, counters=0, armed=0.
- Input synchronizer: i_Rx_Serial passes through 2 flops to give rx_s. All decisions use rx_s only.
- Arming: after reset, the armed flag is set once rx_s==1 is seen. A start bit is accepted only when armed=1. This stops a reset applied mid-frame from locking onto a data bit.
- IDLE:
  - clk_cnt=0, bit_idx=0.
  - If armed and rx_s==0, go to START.
- START:
  - clk_cnt counts up to (CLKS_PER_BIT-1)/2.
  - At that count, if rx_s==0: clk_cnt=0, go to DATA.
  - Otherwise the start bit was a glitch: go to IDLE, with no output pulse.
- DATA:
  - clk_cnt counts 0..CLKS_PER_BIT-1.
  - At CLKS_PER_BIT-1: shift[bit_idx]=rx_s, clk_cnt=0, bit_idx++.
  - After bit_idx 7 is sampled, go to STOP (or to PARITY when the feature is enabled).
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - If rx_s==1:
    - In the next cycle, o_Rx_Byte<=shift and o_Rx_DV=1 for exactly 1 cycle.
    - Go to IDLE.
  - If rx_s==0:
    - o_Frame_Err=1 for 1 cycle; o_Rx_Byte is not updated.
    - Go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. A break condition (line held low) produces exactly one o_Frame_Err.
- o_Rx_Active: 1 in every state except IDLE, and 0 on the cycle o_Rx_DV pulses.
- Latency: the o_Rx_DV rising edge occurs exactly 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 cycles after the falling edge of i_Rx_Serial, within +/-1 cycle of input phase. With parity enabled, add CLKS_PER_BIT.
- Back-to-back frames: a new start bit may begin right after the stop mid-point. IDLE is re-entered within half a bit, so there are no lost frames at the full line rate.
- Simultaneous events: o_Rx_DV and o_Frame_Err are never high in the same cycle.
- Counters never wrap. clk_cnt is cleared on every state transition.
- Asynchronous reset mid-frame: the partial byte is discarded. No pulse is produced, and o_Rx_Byte returns to 0.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP.
  - It samples one bit at mid-point; the expected value is even parity, ^shift.
  - On mismatch, the frame completes through STOP, then pulses o_Frame_Err instead of o_Rx_DV. o_Rx_Byte is not updated.
  - If the stop bit is also bad, there is still a single o_Frame_Err.
- Undefined: no PARITY state; 8N1 behaviour exactly as above.

Test Plan:
- Reset then idle: hold i_Rst_n=0 for 5 cycles, line high → all outputs 0. o_Rx_Active stays 0 for 100 cycles after release.
- Single byte, CLKS_PER_BIT=16: drive 8'hA5 as 8N1 → exactly one o_Rx_DV pulse with o_Rx_Byte=8'hA5, at the latency formula ±1. o_Frame_Err stays 0.
- Back-to-back: send 8'h00, 8'hFF, 8'h3C with no idle gap → three o_Rx_DV pulses, with bytes in order.
- Glitch rejection: drive the line low for 4 cycles (below half a bit at CLKS_PER_BIT=16) → no pulses, and o_Rx_Active returns to 0.
- Framing: send 8'h55 with stop bit 0, then hold low for 3 bit times, then high → one o_Frame_Err pulse. o_Rx_Byte keeps its previous value. A following 8'h12 is received correctly.
- Reset mid-frame: assert i_Rst_n after bit 3 of 8'hC3 and release while the line is still mid-frame → no pulses until the line idles high. The next full frame 8'h7E is received correctly. With UART_RX_PARITY_EN defined, 8'h7E sent with the wrong parity bit → o_Frame_Err, no o_Rx_DV.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
// Two-flop input synchronizer. Arming guard against a reset released mid-frame.
// Outputs: one-cycle o_Rx_DV strobe with a held byte, and a one-cycle o_Frame_Err strobe.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames.
// With it, an even-parity bit is checked between the last data bit and the stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err
);

    localparam logic [CNT_W-1:0] LP_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic             r_rx_meta;
    logic             r_rx_s;
    logic [1:0]       r_sync_fill;
    logic             r_armed;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_par_err;
    logic             r_dv;
    logic             r_ferr;
    logic [7:0]       r_byte;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       w_idx_next;
    logic [7:0]       w_shift_next;
    logic             w_par_err_next;
    logic             w_dv_next;
    logic             w_ferr_next;
    logic [7:0]       w_byte_next;

    // Two-flop synchronizer for the asynchronous serial line (idle level after reset).
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_Rx_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Arm only on a genuine high line.
    // r_sync_fill masks the reset value still sitting in the synchronizer.
    // Without it, a data bit seen right after reset could be taken as a start bit.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_sync_fill <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            r_armed     <= r_armed | (r_sync_fill[1] & r_rx_s);
        end
    end

    // State, counters, shift register and output strobes.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_dv      <= 1'b0;
            r_ferr    <= 1'b0;
            r_byte    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_shift   <= w_shift_next;
            r_par_err <= w_par_err_next;
            r_dv      <= w_dv_next;
            r_ferr    <= w_ferr_next;
            r_byte    <= w_byte_next;
        end
    end

    // Next-state logic.
    // Strobes default low.
    // The bit counter is cleared on every state change, so it never wraps.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_idx_next     = r_idx;
        w_shift_next   = r_shift;
        w_par_err_next = r_par_err;
        w_dv_next      = 1'b0;
        w_ferr_next    = 1'b0;
        w_byte_next    = r_byte;

        case (r_state)
            S_IDLE: begin
                w_cnt_next     = '0;
                w_idx_next     = '0;
                w_par_err_next = 1'b0;
                if (r_armed && !r_rx_s) begin
                    w_state_next = S_START;
                end
            end

            S_START: begin
                if (r_cnt == LP_HALF) begin
                    w_cnt_next   = '0;
                    // Line back high at mid-start: treat as a glitch, drop silently.
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (r_cnt == LP_LAST) begin
                    w_cnt_next          = '0;
                    w_shift_next[r_idx] = r_rx_s;
                    if (r_idx == 3'd7) begin
                        w_idx_next   = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == LP_LAST) begin
                    w_cnt_next     = '0;
                    // Even parity: the parity bit equals the XOR of the data bits.
                    w_par_err_next = (r_rx_s != ^r_shift);
                    w_state_next   = S_STOP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (r_cnt == LP_LAST) begin
                    w_cnt_next = '0;
                    if (r_rx_s && !r_par_err) begin
                        w_dv_next    = 1'b1;
                        w_byte_next  = r_shift;
                        w_state_next = S_IDLE;
                    end else begin
                        // A bad stop bit and a bad parity bit still give one error strobe.
                        w_ferr_next  = 1'b1;
                        w_state_next = r_rx_s ? S_IDLE : S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_WAIT_IDLE: begin
                // A break condition parks here, so it reports only one error.
                w_cnt_next = '0;
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_Rx_DV     = r_dv;
    assign o_Rx_Byte   = r_byte;
    assign o_Frame_Err = r_ferr;
    // The FSM is already back in IDLE on the strobe cycle, so Active is low there too.
    assign o_Rx_Active = (r_state != S_IDLE);

endmodule
